// File: rtl/julia_pkg.sv
// Shared types and fixed-point helpers for the Julia/Mandelbrot escape-time engine.
package julia_pkg;

  typedef enum logic [2:0] {IDLE, INIT, ITER, EMIT, DONE} state_t;

  // Widest fixed-point word the helpers support; callers truncate to their own W.
  localparam int FX_MAX_W = 64;
  localparam int FX_DEF_FRAC = 16;
  localparam logic [31:0] FX_ONE = 32'(1) << FX_DEF_FRAC;

  // Fixed-point multiply: full product, then drop FRAC fractional bits.
  function automatic logic signed [FX_MAX_W-1:0] fx_mul(input logic signed [FX_MAX_W-1:0] a,
                                                        input logic signed [FX_MAX_W-1:0] b,
                                                        input int frac);
    logic signed [2*FX_MAX_W-1:0] p;
    p = (2*FX_MAX_W)'(a) * (2*FX_MAX_W)'(b);
    return FX_MAX_W'(p >>> frac);
  endfunction

  // 8-bit intensity scale: intensity = (iter * int_scale) >> 16.
  function automatic int int_scale(input int max_iter);
    return (255 << 16) / max_iter;
  endfunction

endpackage

// File: rtl/julia_iter_engine_step.sv
// One z <= z^2 + c update with the |z|^2 > 4 escape test, purely combinational.
module julia_step #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic signed [W-1:0] zr,
  input  logic signed [W-1:0] zi,
  input  logic signed [W-1:0] cr,
  input  logic signed [W-1:0] ci,
  output logic signed [W-1:0] zr_next,
  output logic signed [W-1:0] zi_next,
  output logic                escape
);

  localparam logic [2*W:0] ESC_LIM = (2*W+1)'(4) << (2*FRAC);

  logic signed [2*W-1:0] zr2, zi2, zrzi;
  logic signed [2*W:0]   diff;
  logic        [2*W:0]   mag;

  always_comb begin
    zr2  = (2*W)'(zr) * (2*W)'(zr);
    zi2  = (2*W)'(zi) * (2*W)'(zi);
    zrzi = (2*W)'(zr) * (2*W)'(zi);
    mag  = (2*W+1)'(zr2) + (2*W+1)'(zi2);
    diff = (2*W+1)'(zr2) - (2*W+1)'(zi2);
    // Exactly |z|^2 == 4 stays inside the set.
    escape  = mag > ESC_LIM;
    zr_next = W'(diff >>> FRAC) + cr;
    // 2*zr*zi >> FRAC folded into a single shift of FRAC-1.
    zi_next = W'(zrzi >>> (FRAC - 1)) + ci;
  end

endmodule

// File: rtl/julia_iter_engine.sv
// Raster-scanning escape-time engine: one z^2+c step per clock, one result per pixel on a valid/ready stream.
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int MAX_ITER = 100,
  parameter int ITER_W   = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              mode,
  input  logic [W-1:0]      c_re_in,
  input  logic [W-1:0]      c_im_in,
  input  logic [W-1:0]      step_in,
  output logic              busy,
  output logic              done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [ITER_W-1:0] pix_iter,
  output logic              pix_escaped,
  output logic [7:0]        intensity
);

  localparam logic [31:0]       INT_SCALE = 32'(int_scale(MAX_ITER));
  localparam logic [ITER_W-1:0] K_MAX     = ITER_W'(MAX_ITER);

  state_t state, state_next;

  logic                     mode_r;
  logic signed [W-1:0]      c_re_r, c_im_r, step_r;
  logic        [9:0]        hx, vy;
  logic signed [W-1:0]      zr, zi, cr, ci;
  logic        [ITER_W-1:0] k;

  logic signed [W-1:0] off_x, off_y, px, py;
  logic signed [W-1:0] zr_next, zi_next;
  logic                escape, last_pix, hs;

  julia_step #(.W(W), .FRAC(FRAC)) u_step (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr),
    .ci      (ci),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escape  (escape)
  );

  // Pixel offset from the frame centre, promoted to fixed point before scaling by step.
  always_comb begin
    off_x    = (W'(hx) - W'(IMG_W / 2)) << FRAC;
    off_y    = (W'(vy) - W'(IMG_H / 2)) << FRAC;
    px       = W'(fx_mul(FX_MAX_W'(off_x), FX_MAX_W'(step_r), FRAC));
    py       = W'(fx_mul(FX_MAX_W'(off_y), FX_MAX_W'(step_r), FRAC));
    last_pix = (hx == 10'(IMG_W - 1)) && (vy == 10'(IMG_H - 1));
    hs       = (state == EMIT) && pix_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: state_next = ITER;
      ITER: if (escape || k == K_MAX) state_next = EMIT;
      EMIT: if (pix_ready) state_next = last_pix ? DONE : INIT;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    pix_valid = (state == EMIT);
    pix_x     = hx;
    pix_y     = vy;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_r      <= 1'b0;
      c_re_r      <= '0;
      c_im_r      <= '0;
      step_r      <= '0;
      hx          <= '0;
      vy          <= '0;
      zr          <= '0;
      zi          <= '0;
      cr          <= '0;
      ci          <= '0;
      k           <= '0;
      pix_iter    <= '0;
      pix_escaped <= 1'b0;
      intensity   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_r <= mode;
          c_re_r <= c_re_in;
          c_im_r <= c_im_in;
          step_r <= step_in;
          hx     <= '0;
          vy     <= '0;
        end
        INIT: begin
          if (mode_r) begin
            zr <= '0;
            zi <= '0;
            cr <= px;
            ci <= py;
          end else begin
            zr <= px;
            zi <= py;
            cr <= c_re_r;
            ci <= c_im_r;
          end
          k <= '0;
        end
        ITER: begin
          if (escape) begin
            pix_iter    <= k;
            pix_escaped <= 1'b1;
            intensity   <= 8'((32'(k) * INT_SCALE) >> 16);
          end else if (k == K_MAX) begin
            pix_iter    <= K_MAX;
            pix_escaped <= 1'b0;
            intensity   <= '0;
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            k  <= k + ITER_W'(1);
          end
        end
        EMIT: if (hs && !last_pix) begin
          if (hx == 10'(IMG_W - 1)) begin
            hx <= '0;
            vy <= vy + 10'd1;
          end else begin
            hx <= hx + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
